gnn_layer_seq: RTL and testbench

//  Parametrised, time-multiplexed single GNN layer: neighbour aggregation over a runtime adjacency mask,

---
 rtl/gnn_layer_if.sv | 36 +++
 rtl/gnn_layer_seq.sv | 150 +++++++++++++++
 tb/tb_gnn_layer_seq.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gnn_layer_if.sv
// Handshake/data bundle for gnn_layer_seq: job input side, per-node result side, status and FSM debug.
// Valid/ready: a transfer happens on a rising edge where valid && ready; valid and its payload stay stable until then.
interface gnn_layer_if #(
  parameter int N_NODES = 4,
  parameter int F_IN    = 4,
  parameter int F_OUT   = 2,
  parameter int DW      = 5,
  parameter int WW      = 5,
  parameter int OUT_W   = 21
);
  localparam int NW = $clog2(N_NODES);

  logic                          in_valid;
  logic                          in_ready;
  logic [N_NODES*F_IN*DW-1:0]    x_flat;
  logic [N_NODES*N_NODES-1:0]    adj;
  logic [F_IN*F_OUT*WW-1:0]      w_flat;
  logic                          relu_en;
  logic                          out_valid;
  logic                          out_ready;
  logic [NW-1:0]                 out_node;
  logic [F_OUT*OUT_W-1:0]        out_feat;
  logic                          busy;
  logic                          done;
  logic [1:0]                    dbg_state;

  modport slave (
    input  in_valid, x_flat, adj, w_flat, relu_en, out_ready,
    output in_ready, out_valid, out_node, out_feat, busy, done, dbg_state
  );

  modport master (
    output in_valid, x_flat, adj, w_flat, relu_en, out_ready,
    input  in_ready, out_valid, out_node, out_feat, busy, done, dbg_state
  );
endinterface

// File: rtl/gnn_layer_seq.sv
// Time-multiplexed GNN layer: per node, masked neighbour sum (AGG), dense transform (XFORM),
// then ReLU/saturation and a held result until the downstream accepts it (OUT).
module gnn_layer_seq #(
  parameter int N_NODES = 4,
  parameter int F_IN    = 4,
  parameter int F_OUT   = 2,
  parameter int DW      = 5,
  parameter int WW      = 5,
  parameter int OUT_W   = 21,
  parameter bit SAT     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  gnn_layer_if.slave  bus
);
  localparam int NW  = $clog2(N_NODES);
  localparam int AGW = DW + $clog2(N_NODES) + 1;
  localparam int ACW = AGW + WW + $clog2(F_IN) + 1;
  localparam int PW  = AGW + WW;
  localparam int RW  = ((ACW > OUT_W) ? ACW : OUT_W) + 1;
  localparam int CW  = $clog2(N_NODES + F_IN) + 1;
  // Clamp limits live in a width wide enough for both the accumulator and OUT_W.
  localparam logic signed [RW-1:0] MAX_V = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] MIN_V = ~MAX_V;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_AGG   = 2'd1;
  localparam logic [1:0] S_XFORM = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]                 state_r;
  logic [CW-1:0]              cnt_r;
  logic [NW-1:0]              node_r;
  logic [N_NODES*F_IN*DW-1:0] x_r;
  logic [N_NODES*N_NODES-1:0] adj_r;
  logic [F_IN*F_OUT*WW-1:0]   w_r;
  logic                       relu_r;
  logic [F_IN*AGW-1:0]        agg_r, agg_nx;
  logic [F_OUT*ACW-1:0]       acc_r, acc_nx;
  logic [F_OUT*OUT_W-1:0]     feat_r, feat_nx;
  logic                       done_r;

  always_comb begin
    logic                   take;
    logic signed [DW-1:0]   xj;
    logic signed [AGW-1:0]  ak;
    logic signed [WW-1:0]   wk;
    logic signed [PW-1:0]   prod;
    logic signed [RW-1:0]   rv;
    agg_nx  = '0;
    acc_nx  = '0;
    feat_nx = '0;
    xj      = '0;
    wk      = '0;
    prod    = '0;
    rv      = '0;
    // cnt_r is the neighbour index j in AGG and the input-feature index k in XFORM.
    take = adj_r[int'(node_r)*N_NODES + int'(cnt_r) +: 1];
    ak   = $signed(agg_r[int'(cnt_r)*AGW +: AGW]);
    for (int f = 0; f < F_IN; f++) begin
      xj = $signed(x_r[(int'(cnt_r)*F_IN + f)*DW +: DW]);
      agg_nx[f*AGW +: AGW] = $signed(agg_r[f*AGW +: AGW]) + (take ? AGW'(xj) : '0);
    end
    for (int o = 0; o < F_OUT; o++) begin
      wk   = $signed(w_r[(int'(cnt_r)*F_OUT + o)*WW +: WW]);
      prod = PW'(ak) * PW'(wk);
      acc_nx[o*ACW +: ACW] = $signed(acc_r[o*ACW +: ACW]) + ACW'(prod);
      rv = RW'($signed(acc_nx[o*ACW +: ACW]));
      if (relu_r && rv[RW-1]) rv = '0;
      if (SAT) begin
        if (rv > MAX_V)      rv = MAX_V;
        else if (rv < MIN_V) rv = MIN_V;
      end
      feat_nx[o*OUT_W +: OUT_W] = rv[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
      node_r  <= '0;
      x_r     <= '0;
      adj_r   <= '0;
      w_r     <= '0;
      relu_r  <= 1'b0;
      agg_r   <= '0;
      acc_r   <= '0;
      feat_r  <= '0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (bus.in_valid) begin
            x_r     <= bus.x_flat;
            adj_r   <= bus.adj;
            w_r     <= bus.w_flat;
            relu_r  <= bus.relu_en;
            node_r  <= '0;
            cnt_r   <= '0;
            agg_r   <= '0;
            state_r <= S_AGG;
          end
        end
        S_AGG: begin
          agg_r <= agg_nx;
          if (cnt_r == CW'(N_NODES - 1)) begin
            cnt_r   <= '0;
            acc_r   <= '0;
            state_r <= S_XFORM;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        S_XFORM: begin
          acc_r <= acc_nx;
          if (cnt_r == CW'(F_IN - 1)) begin
            cnt_r   <= '0;
            feat_r  <= feat_nx;
            state_r <= S_OUT;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            if (node_r == NW'(N_NODES - 1)) begin
              done_r  <= 1'b1;
              state_r <= S_IDLE;
            end else begin
              node_r  <= node_r + 1'b1;
              agg_r   <= '0;
              state_r <= S_AGG;
            end
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_r == S_IDLE);
  assign bus.busy      = (state_r != S_IDLE);
  assign bus.out_valid = (state_r == S_OUT);
  assign bus.out_node  = node_r;
  assign bus.out_feat  = feat_r;
  assign bus.done      = done_r;
  assign bus.dbg_state = state_r;
endmodule

// File: tb/tb_gnn_layer_seq.sv
// Directed bench for gnn_layer_seq: default layer, saturating/truncating 8-bit variants,
// and an 8-node/3-in/5-out variant checked against a small integer model.
module tb_gnn_layer_seq;
  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  gnn_layer_if #() ia ();
  gnn_layer_if #(.OUT_W(8)) is_ ();
  gnn_layer_if #(.OUT_W(8)) it_ ();
  gnn_layer_if #(.N_NODES(8), .F_IN(3), .F_OUT(5)) ib ();

  gnn_layer_seq #() dut_a (.clk(clk), .rst(rst), .bus(ia));
  gnn_layer_seq #(.OUT_W(8), .SAT(1'b1)) dut_s (.clk(clk), .rst(rst), .bus(is_));
  gnn_layer_seq #(.OUT_W(8), .SAT(1'b0)) dut_t (.clk(clk), .rst(rst), .bus(it_));
  gnn_layer_seq #(.N_NODES(8), .F_IN(3), .F_OUT(5)) dut_b (.clk(clk), .rst(rst), .bus(ib));

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint fa(int o);
    return longint'($signed(ia.out_feat[o*21 +: 21]));
  endfunction
  function automatic longint fs(int o);
    return longint'($signed(is_.out_feat[o*8 +: 8]));
  endfunction
  function automatic longint ft(int o);
    return longint'($signed(it_.out_feat[o*8 +: 8]));
  endfunction
  function automatic longint fb(int o);
    return longint'($signed(ib.out_feat[o*21 +: 21]));
  endfunction

  // driver tasks for the default-parameter instance
  task automatic start_a(input int xv, input logic [15:0] adjv, input int w0, input int w1, input bit relu);
    for (int i = 0; i < 16; i++) ia.x_flat[i*5 +: 5] = 5'(xv);
    for (int k = 0; k < 4; k++) begin
      ia.w_flat[(k*2)*5 +: 5]   = 5'(w0);
      ia.w_flat[(k*2+1)*5 +: 5] = 5'(w1);
    end
    ia.adj      = adjv;
    ia.relu_en  = relu;
    ia.in_valid = 1'b1;
    @(negedge clk);
    ia.in_valid = 1'b0;
  endtask

  task automatic collect_a(input string tag, input longint e0, input longint e1,
                           input int stall_node, input bit chk_lat);
    for (int n = 0; n < 4; n++) begin
      int c;
      c = 0;
      while (ia.out_valid !== 1'b1 && c < 40) begin
        @(negedge clk);
        c++;
      end
      check({tag, "_valid"}, ia.out_valid, 1);
      if (chk_lat) check({tag, "_lat"}, c + 1, 9);
      check({tag, "_node"}, ia.out_node, n);
      check({tag, "_f0"}, fa(0), e0);
      check({tag, "_f1"}, fa(1), e1);
      if (n == stall_node) begin
        ia.out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          if (s == 1) begin
            for (int i = 0; i < 16; i++) ia.x_flat[i*5 +: 5] = 5'd7;
            ia.in_valid = 1'b1;
          end
          if (s == 3) ia.in_valid = 1'b0;
          @(negedge clk);
          check({tag, "_hold_valid"}, ia.out_valid, 1);
          check({tag, "_hold_node"}, ia.out_node, n);
          check({tag, "_hold_f0"}, fa(0), e0);
          check({tag, "_hold_f1"}, fa(1), e1);
          check({tag, "_hold_in_ready"}, ia.in_ready, 0);
          check({tag, "_hold_busy"}, ia.busy, 1);
        end
        ia.in_valid  = 1'b0;
        ia.out_ready = 1'b1;
      end
      @(negedge clk);
      if (n < 3) begin
        check({tag, "_drop_valid"}, ia.out_valid, 0);
        check({tag, "_mid_done"}, ia.done, 0);
      end else begin
        check({tag, "_done"}, ia.done, 1);
        check({tag, "_end_in_ready"}, ia.in_ready, 1);
        check({tag, "_end_busy"}, ia.busy, 0);
        check({tag, "_end_valid"}, ia.out_valid, 0);
      end
    end
    @(negedge clk);
    check({tag, "_done_pulse"}, ia.done, 0);
    check({tag, "_idle_valid"}, ia.out_valid, 0);
  endtask

  // driver for the two 8-bit instances run in lockstep
  task automatic run_st(input string tag, input int xv, input int w0, input int w1,
                        input longint es0, input longint es1, input longint et0, input longint et1);
    for (int i = 0; i < 16; i++) begin
      is_.x_flat[i*5 +: 5] = 5'(xv);
      it_.x_flat[i*5 +: 5] = 5'(xv);
    end
    for (int k = 0; k < 4; k++) begin
      is_.w_flat[(k*2)*5 +: 5]   = 5'(w0);
      is_.w_flat[(k*2+1)*5 +: 5] = 5'(w1);
      it_.w_flat[(k*2)*5 +: 5]   = 5'(w0);
      it_.w_flat[(k*2+1)*5 +: 5] = 5'(w1);
    end
    is_.adj = 16'hFFFF;
    it_.adj = 16'hFFFF;
    is_.in_valid = 1'b1;
    it_.in_valid = 1'b1;
    @(negedge clk);
    is_.in_valid = 1'b0;
    it_.in_valid = 1'b0;
    for (int n = 0; n < 4; n++) begin
      int c;
      c = 0;
      while (is_.out_valid !== 1'b1 && c < 40) begin
        @(negedge clk);
        c++;
      end
      check({tag, "_s_valid"}, is_.out_valid, 1);
      check({tag, "_t_valid"}, it_.out_valid, 1);
      check({tag, "_s_node"}, is_.out_node, n);
      check({tag, "_s_f0"}, fs(0), es0);
      check({tag, "_s_f1"}, fs(1), es1);
      check({tag, "_t_f0"}, ft(0), et0);
      check({tag, "_t_f1"}, ft(1), et1);
      @(negedge clk);
    end
    check({tag, "_s_done"}, is_.done, 1);
    check({tag, "_t_done"}, it_.done, 1);
    @(negedge clk);
  endtask

  // reference model for the 8-node instance
  int xb [8][3];
  int wb [3][5];

  function automatic longint model_b(int n, int o, logic [63:0] adjv, bit relu);
    longint acc;
    longint agg;
    acc = 0;
    for (int k = 0; k < 3; k++) begin
      agg = 0;
      for (int j = 0; j < 8; j++) if (adjv[n*8 + j]) agg += xb[j][k];
      acc += agg * wb[k][o];
    end
    if (relu && acc < 0) acc = 0;
    if (acc > 1048575) acc = 1048575;
    if (acc < -1048576) acc = -1048576;
    return acc;
  endfunction

  task automatic run_b(input string tag, input logic [63:0] adjv, input bit relu);
    for (int n = 0; n < 8; n++)
      for (int f = 0; f < 3; f++) ib.x_flat[(n*3 + f)*5 +: 5] = 5'(xb[n][f]);
    for (int k = 0; k < 3; k++)
      for (int o = 0; o < 5; o++) ib.w_flat[(k*5 + o)*5 +: 5] = 5'(wb[k][o]);
    ib.adj      = adjv;
    ib.relu_en  = relu;
    ib.in_valid = 1'b1;
    @(negedge clk);
    ib.in_valid = 1'b0;
    for (int n = 0; n < 8; n++) begin
      int c;
      c = 0;
      while (ib.out_valid !== 1'b1 && c < 40) begin
        @(negedge clk);
        c++;
      end
      check({tag, "_valid"}, ib.out_valid, 1);
      check({tag, "_period"}, c + 1, 12);
      check({tag, "_node"}, ib.out_node, n);
      for (int o = 0; o < 5; o++) begin
        check({tag, "_feat"}, fb(o), model_b(n, o, adjv, relu));
        if (adjv[n*8 +: 8] == 8'h00) check({tag, "_empty_row"}, fb(o), 0);
      end
      @(negedge clk);
    end
    check({tag, "_done"}, ib.done, 1);
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] adj_b;
    rst = 1'b1;
    ia.in_valid = 1'b0;  ia.x_flat = '0;  ia.adj = '0;  ia.w_flat = '0;  ia.relu_en = 1'b0;  ia.out_ready = 1'b1;
    is_.in_valid = 1'b0; is_.x_flat = '0; is_.adj = '0; is_.w_flat = '0; is_.relu_en = 1'b0; is_.out_ready = 1'b1;
    it_.in_valid = 1'b0; it_.x_flat = '0; it_.adj = '0; it_.w_flat = '0; it_.relu_en = 1'b0; it_.out_ready = 1'b1;
    ib.in_valid = 1'b0;  ib.x_flat = '0;  ib.adj = '0;  ib.w_flat = '0;  ib.relu_en = 1'b0;  ib.out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_in_ready", ia.in_ready, 1);
    check("rst_out_valid", ia.out_valid, 0);
    check("rst_out_node", ia.out_node, 0);
    check("rst_out_feat", longint'(ia.out_feat), 0);
    check("rst_busy", ia.busy, 0);
    check("rst_done", ia.done, 0);
    check("rst_b_in_ready", ib.in_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // fully connected, all ones: 4 neighbours x 4 features -> 16
    start_a(1, 16'hFFFF, 1, 1, 1'b0);
    collect_a("full", 16, 16, -1, 1'b1);

    // ring adjacency: 3 neighbours x 4 features -> 12
    start_a(1, 16'hDE7B, 1, 1, 1'b0);
    collect_a("ring", 12, 12, -1, 1'b1);
    start_a(1, 16'hDE7B, 1, -1, 1'b0);
    collect_a("ring_neg", 12, -12, -1, 1'b0);
    start_a(1, 16'hDE7B, 1, -1, 1'b1);
    collect_a("ring_relu", 12, 0, -1, 1'b0);

    // backpressure at node 1 with in_valid pulsed while busy
    start_a(1, 16'hFFFF, 1, 1, 1'b0);
    collect_a("stall", 16, 16, 1, 1'b0);

    // 8-bit output: +4096 / -3840 clamp or wrap; +528 / -528; small values pass through
    run_st("sat_big", -16, -16, 15, 127, -128, 0, 0);
    run_st("sat_mid", 3, 11, -11, 127, -128, 16, -16);
    run_st("sat_small", 1, 1, -1, 16, -16, 16, -16);

    // reset during XFORM of node 2 aborts the job without a done pulse
    start_a(1, 16'hFFFF, 1, 1, 1'b0);
    begin
      int c;
      c = 0;
      while (!(ia.dbg_state == 2'd2 && ia.out_node == 2'd2) && c < 60) begin
        @(negedge clk);
        c++;
      end
    end
    check("abort_reach_xform", ia.dbg_state, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_state", ia.dbg_state, 0);
    check("abort_in_ready", ia.in_ready, 1);
    check("abort_out_valid", ia.out_valid, 0);
    check("abort_out_node", ia.out_node, 0);
    check("abort_out_feat", longint'(ia.out_feat), 0);
    check("abort_busy", ia.busy, 0);
    check("abort_done", ia.done, 0);
    @(negedge clk);
    check("abort_no_done", ia.done, 0);
    start_a(1, 16'hDE7B, 1, 1, 1'b0);
    collect_a("after_abort", 12, 12, -1, 1'b1);

    // 8 nodes, 3 in, 5 out: empty row 5, random data, then relu and extreme values
    for (int n = 0; n < 8; n++) for (int f = 0; f < 3; f++) xb[n][f] = int'($urandom_range(0, 31)) - 16;
    for (int k = 0; k < 3; k++) for (int o = 0; o < 5; o++) wb[k][o] = int'($urandom_range(0, 31)) - 16;
    adj_b = {$urandom, $urandom};
    adj_b[5*8 +: 8] = 8'h00;
    run_b("b_rand", adj_b, 1'b0);
    adj_b = {$urandom, $urandom};
    run_b("b_relu", adj_b, 1'b1);
    for (int n = 0; n < 8; n++) for (int f = 0; f < 3; f++) xb[n][f] = -16;
    for (int k = 0; k < 3; k++) for (int o = 0; o < 5; o++) wb[k][o] = (o == 0) ? 15 : -16;
    run_b("b_extreme", {64{1'b1}}, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
